// File: rtl/lfu_finder_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lfu_finder_n : N-entry least-frequently-used victim finder with saturating |
// |                per-buffer counters; LFU_AGING_EN enables halving on sat.   |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module lfu_finder_n #(
  parameter int NBUF  = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ref_vld,
  input  logic [IDX_W-1:0] ref_buf_numbr,
  input  logic             new_buf_req,
  output logic [IDX_W-1:0] buf_num_replc,
  output logic             age_pls
);

  localparam int               NLEAF = 1 << IDX_W;
  localparam int               NNODE = 2 * NLEAF - 1;
  localparam logic [CNT_W-1:0] CMAX  = '1;

  logic [CNT_W-1:0] cnt_q [NBUF];
  logic [CNT_W-1:0] cnt_d [NBUF];
  logic [IDX_W-1:0] replc_q;
  logic [IDX_W-1:0] replc_d;
  logic             age_q;
  logic             age_d;
  logic             ref_ok;
  logic [CNT_W-1:0] ref_cnt;

  logic [CNT_W-1:0] node_cnt [NNODE];
  logic [IDX_W-1:0] node_idx [NNODE];
  logic             node_vld [NNODE];

  // Out-of-range indices (non-power-of-2 pools) are treated as no reference.
  always_comb begin
    ref_ok  = ref_vld && ({1'b0, ref_buf_numbr} < (IDX_W + 1)'(NBUF));
    ref_cnt = '0;
    for (int i = 0; i < NBUF; i++) begin
      if (ref_buf_numbr == IDX_W'(i)) begin
        ref_cnt = cnt_q[i];
      end
    end
`ifdef LFU_AGING_EN
    age_d = ref_ok && (ref_cnt == CMAX);
`else
    age_d = 1'b0;
`endif
  end

  always_comb begin
    for (int i = 0; i < NBUF; i++) begin
      cnt_d[i] = age_d ? (cnt_q[i] >> 1) : cnt_q[i];
      if (new_buf_req && (replc_q == IDX_W'(i))) begin
        cnt_d[i] = '0;
      end
      if (ref_ok && (ref_buf_numbr == IDX_W'(i)) && (cnt_d[i] != CMAX)) begin
        cnt_d[i] = cnt_d[i] + CNT_W'(1);
      end
    end
  end

  // Binary min-tree over the next-state counts; the left child carries the
  // lower indices, so equal counts resolve toward the left.
  always_comb begin
    for (int i = 0; i < NBUF; i++) begin
      node_cnt[NLEAF-1+i] = cnt_d[i];
      node_idx[NLEAF-1+i] = IDX_W'(i);
      node_vld[NLEAF-1+i] = 1'b1;
    end
    for (int i = NBUF; i < NLEAF; i++) begin
      node_cnt[NLEAF-1+i] = '0;
      node_idx[NLEAF-1+i] = IDX_W'(i);
      node_vld[NLEAF-1+i] = 1'b0;
    end
    for (int k = NLEAF - 2; k >= 0; k--) begin
      if (node_vld[2*k+2] &&
          (!node_vld[2*k+1] || (node_cnt[2*k+2] < node_cnt[2*k+1]))) begin
        node_cnt[k] = node_cnt[2*k+2];
        node_idx[k] = node_idx[2*k+2];
      end else begin
        node_cnt[k] = node_cnt[2*k+1];
        node_idx[k] = node_idx[2*k+1];
      end
      node_vld[k] = node_vld[2*k+1] | node_vld[2*k+2];
    end
    replc_d = node_idx[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBUF; i++) begin
        cnt_q[i] <= '0;
      end
      replc_q <= '0;
      age_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NBUF; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      replc_q <= replc_d;
      age_q   <= age_d;
    end
  end

  assign buf_num_replc = replc_q;
  assign age_pls       = age_q;

endmodule
`default_nettype wire

// File: tb/tb_lfu_finder_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lfu_finder_n : directed and randomized checks of lfu_finder_n for a     |
// |                   4-entry and a 5-entry pool; honours LFU_AGING_EN.        |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_lfu_finder_n;

  localparam int CMAX = 15;

  logic       clk;
  logic       rst_n;
  logic       vld4, req4, vld5, req5;
  logic [1:0] ref4;
  logic [2:0] ref5;
  logic [1:0] replc4;
  logic [2:0] replc5;
  logic       age4, age5;

  int checks;
  int failures;

  // Reference state per pool: u=0 is the 4-entry pool, u=1 the 5-entry pool.
  int m_cnt [2][16];
  int m_rep [2];
  bit m_age [2];
  int m_n   [2];

  lfu_finder_n #(.NBUF(4), .IDX_W(2), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ref_vld(vld4), .ref_buf_numbr(ref4),
    .new_buf_req(req4), .buf_num_replc(replc4), .age_pls(age4)
  );

  lfu_finder_n #(.NBUF(5), .IDX_W(3), .CNT_W(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .ref_vld(vld5), .ref_buf_numbr(ref5),
    .new_buf_req(req5), .buf_num_replc(replc5), .age_pls(age5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 16; i++) m_cnt[u][i] = 0;
      m_rep[u] = 0;
      m_age[u] = 0;
    end
  endtask

  task automatic model_step(input int u, input bit vld, input int r, input bit req);
    int  n;
    bit  hit;
    int  best;
    n   = m_n[u];
    hit = vld && (r < n);
    m_age[u] = 0;
`ifdef LFU_AGING_EN
    if (hit && m_cnt[u][r] == CMAX) begin
      for (int i = 0; i < n; i++) m_cnt[u][i] = m_cnt[u][i] / 2;
      m_age[u] = 1;
    end
`endif
    if (req) m_cnt[u][m_rep[u]] = 0;
    if (hit && m_cnt[u][r] < CMAX) m_cnt[u][r] = m_cnt[u][r] + 1;
    best = 0;
    for (int i = 1; i < n; i++) if (m_cnt[u][i] < m_cnt[u][best]) best = i;
    m_rep[u] = best;
  endtask

  task automatic step(input bit v4, input int r4, input bit q4,
                      input bit v5, input int r5, input bit q5);
    vld4 = v4; ref4 = r4[1:0]; req4 = q4;
    vld5 = v5; ref5 = r5[2:0]; req5 = q5;
    @(posedge clk);
    model_step(0, v4, r4, q4);
    model_step(1, v5, r5, q5);
    #1;
  endtask

  task automatic step4(input int r, input bit q);
    step(1'b1, r, q, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    vld4 = 0; ref4 = 0; req4 = 0; vld5 = 0; ref5 = 0; req5 = 0;
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    int exp4 [4];
    do_reset();
    for (int k = 0; k < 16; k++) step4(0, 1'b0);
    checks++;
    if (replc4 !== 2'd1) begin
      failures++;
      $display("FAIL pre_reset_replc: got %0d want 1", replc4);
    end
`ifdef LFU_AGING_EN
    exp4 = '{8, 0, 0, 0};
`else
    exp4 = '{15, 0, 0, 0};
`endif
    checks++;
    if (int'(u_dut4.cnt_q[0]) != exp4[0]) begin
      failures++;
      $display("FAIL pre_reset_cnt0: got %0d want %0d", u_dut4.cnt_q[0], exp4[0]);
    end
    vld4 = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (replc4 !== 2'd0 || age4 !== 1'b0 || replc5 !== 3'd0 || age5 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_out: got replc4=%0d age4=%0d replc5=%0d age5=%0d want 0",
               replc4, age4, replc5, age5);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (u_dut4.cnt_q[i] !== 4'd0) begin
        failures++;
        $display("FAIL async_reset_cnt%0d: got %0d want 0", i, u_dut4.cnt_q[i]);
      end
    end
    #2 rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_refs();
    int r_seq [7] = '{0, 1, 2, 3, 1, 0, 2};
    int exp [4] = '{2, 2, 2, 1};
    do_reset();
    for (int k = 0; k < 7; k++) step4(r_seq[k], 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (int'(u_dut4.cnt_q[i]) != exp[i]) begin
        failures++;
        $display("FAIL refs_cnt%0d: got %0d want %0d", i, u_dut4.cnt_q[i], exp[i]);
      end
    end
    checks++;
    if (replc4 !== 2'd3) begin
      failures++;
      $display("FAIL refs_replc: got %0d want 3", replc4);
    end
  endtask

  task automatic test_tiebreak();
    do_reset();
    step4(0, 1'b0);
    step4(1, 1'b0);
    checks++;
    if (replc4 !== 2'd2) begin
      failures++;
      $display("FAIL tie_two_zero: got %0d want 2", replc4);
    end
    step4(2, 1'b0);
    step4(3, 1'b0);
    checks++;
    if (replc4 !== 2'd0) begin
      failures++;
      $display("FAIL tie_all_one: got %0d want 0", replc4);
    end
  endtask

  task automatic test_aging();
    int exp [4];
    bit exp_age;
    do_reset();
    for (int k = 0; k < 15; k++) step4(0, 1'b0);
    step4(1, 1'b0);
    step4(1, 1'b0);
    checks++;
    if (age4 !== 1'b0) begin
      failures++;
      $display("FAIL aging_pre_pulse: got %0d want 0", age4);
    end
    step4(0, 1'b0);
`ifdef LFU_AGING_EN
    exp = '{8, 1, 0, 0};
    exp_age = 1'b1;
`else
    exp = '{15, 2, 0, 0};
    exp_age = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (int'(u_dut4.cnt_q[i]) != exp[i]) begin
        failures++;
        $display("FAIL aging_cnt%0d: got %0d want %0d", i, u_dut4.cnt_q[i], exp[i]);
      end
    end
    checks++;
    if (age4 !== exp_age || replc4 !== 2'd2) begin
      failures++;
      $display("FAIL aging_edge: got age=%0d replc=%0d want age=%0d replc=2",
               age4, replc4, exp_age);
    end
    step(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    checks++;
    if (age4 !== 1'b0) begin
      failures++;
      $display("FAIL aging_one_cycle: got %0d want 0", age4);
    end
  endtask

  task automatic test_replacement();
    int e1 [4] = '{3, 0, 2, 4};
    int e3 [4] = '{3, 0, 2, 5};
    do_reset();
    for (int k = 0; k < 3; k++) step4(0, 1'b0);
    for (int k = 0; k < 2; k++) step4(1, 1'b0);
    for (int k = 0; k < 2; k++) step4(2, 1'b0);
    for (int k = 0; k < 4; k++) step4(3, 1'b0);
    checks++;
    if (replc4 !== 2'd1) begin
      failures++;
      $display("FAIL repl_setup: got %0d want 1", replc4);
    end
    step(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (int'(u_dut4.cnt_q[i]) != e1[i]) begin
        failures++;
        $display("FAIL repl_clear_cnt%0d: got %0d want %0d", i, u_dut4.cnt_q[i], e1[i]);
      end
    end
    step4(1, 1'b1);
    checks++;
    if (u_dut4.cnt_q[1] !== 4'd1 || replc4 !== 2'd1) begin
      failures++;
      $display("FAIL repl_clear_inc: got cnt1=%0d replc=%0d want cnt1=1 replc=1",
               u_dut4.cnt_q[1], replc4);
    end
    step4(3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (int'(u_dut4.cnt_q[i]) != e3[i]) begin
        failures++;
        $display("FAIL repl_other_cnt%0d: got %0d want %0d", i, u_dut4.cnt_q[i], e3[i]);
      end
    end
    checks++;
    if (replc4 !== 2'd1) begin
      failures++;
      $display("FAIL repl_other_replc: got %0d want 1", replc4);
    end
  endtask

  task automatic test_nbuf5();
    do_reset();
    step(1'b0, 0, 1'b0, 1'b1, 6, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (u_dut5.cnt_q[i] !== 4'd0) begin
        failures++;
        $display("FAIL n5_oob_cnt%0d: got %0d want 0", i, u_dut5.cnt_q[i]);
      end
    end
    for (int r = 0; r < 4; r++) step(1'b0, 0, 1'b0, 1'b1, r, 1'b0);
    checks++;
    if (replc5 !== 3'd4) begin
      failures++;
      $display("FAIL n5_replc: got %0d want 4", replc5);
    end
    step(1'b0, 0, 1'b0, 1'b1, 7, 1'b0);
    checks++;
    if (replc5 !== 3'd4 || u_dut5.cnt_q[4] !== 4'd0 || age5 !== 1'b0) begin
      failures++;
      $display("FAIL n5_oob_late: got replc=%0d cnt4=%0d age=%0d want 4 0 0",
               replc5, u_dut5.cnt_q[4], age5);
    end
  endtask

  task automatic test_random();
    bit v4, q4, v5, q5;
    int r4, r5;
    do_reset();
    for (int c = 0; c < 3000 && failures < 20; c++) begin
      v4 = ($urandom_range(0, 3) != 0);
      r4 = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(0, 3));
      q4 = ($urandom_range(0, 7) == 0);
      v5 = ($urandom_range(0, 3) != 0);
      r5 = ($urandom_range(0, 9) < 5) ? 1 : int'($urandom_range(0, 7));
      q5 = ($urandom_range(0, 7) == 0);
      step(v4, r4, q4, v5, r5, q5);
      checks++;
      if (int'(replc4) != m_rep[0] || age4 !== m_age[0]) begin
        failures++;
        $display("FAIL rnd4_out c=%0d: got replc=%0d age=%0d want replc=%0d age=%0d",
                 c, replc4, age4, m_rep[0], m_age[0]);
      end
      checks++;
      if (int'(replc5) != m_rep[1] || age5 !== m_age[1]) begin
        failures++;
        $display("FAIL rnd5_out c=%0d: got replc=%0d age=%0d want replc=%0d age=%0d",
                 c, replc5, age5, m_rep[1], m_age[1]);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (int'(u_dut4.cnt_q[i]) != m_cnt[0][i]) begin
          failures++;
          $display("FAIL rnd4_cnt%0d c=%0d: got %0d want %0d", i, c, u_dut4.cnt_q[i], m_cnt[0][i]);
        end
      end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (int'(u_dut5.cnt_q[i]) != m_cnt[1][i]) begin
          failures++;
          $display("FAIL rnd5_cnt%0d c=%0d: got %0d want %0d", i, c, u_dut5.cnt_q[i], m_cnt[1][i]);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_n[0]   = 4;
    m_n[1]   = 5;
    rst_n    = 1'b0;
    vld4 = 0; ref4 = 0; req4 = 0; vld5 = 0; ref5 = 0; req5 = 0;
    model_clear();
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_refs();
    test_tiebreak();
    test_aging();
    test_replacement();
    test_nbuf5();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lfu_finder_n.md
# lfu_finder_n

Parametrised least-frequently-used replacement finder for an N-entry buffer pool. It tracks a saturating reference counter per buffer and continuously reports the buffer with the lowest count as the replacement victim. On a new-buffer request it clears the victim's counter, so a freshly loaded buffer starts with no history. It sits beside the buffer-pool controller and generalises the 4-entry LFU finder to any pool size and counter width, and adds an explicit reference-valid strobe and optional counter aging.

## Interface
- NBUF, 4, number of buffers (≥2)
- IDX_W, 2, buffer index width (= ceil(log2 NBUF))
- CNT_W, 4, per-buffer counter width (≥2); max count CMAX = 2^CNT_W−1
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ref_vld  in  1  reference strobe; ref_buf_numbr sampled only when 1
- ref_buf_numbr  in  IDX_W  index of referenced buffer
- new_buf_req  in  1  request to replace the current victim
- buf_num_replc  out  IDX_W  registered victim index
- age_pls  out  1  one-cycle pulse, aging applied this edge

## Operation
- State: cnt[0..NBUF−1] (CNT_W each), buf_num_replc, age_pls. All reset to 0.
- Per edge, next counts computed in this order from current counts:
  1. Aging: if AGING enabled, ref_vld=1, and cnt[ref]==CMAX, every counter is shifted right by 1 and age_pls is set for one cycle; otherwise age_pls=0.
  2. Clear: if new_buf_req=1, counter at index buf_num_replc (current registered value) becomes 0.
  3. Increment: if ref_vld=1, cnt[ref] += 1; without aging, a counter at CMAX holds (saturates, never wraps).
- Simultaneous new_buf_req and ref to the victim: victim ends at 1 (clear, then increment).
- Simultaneous aging and new_buf_req: victim ends at 0 (clear overrides its halved value), or 1 if it is also the referenced buffer.
- ref_buf_numbr ≥ NBUF (non-power-of-2 NBUF) with ref_vld=1: reference ignored, no aging, no increment.
- X on ref_buf_numbr while ref_vld=0: no effect.
- Victim selection: minimum of the next-state counts; ties go to lowest index. Result registered into buf_num_replc on the same edge the counts update.

## Timing
- Reference/request sampled at edge N; counts and buf_num_replc reflect it after edge N (one-cycle latency, output is always consistent with counter state).
- age_pls high exactly for the cycle following the aging edge.
- new_buf_req is level-sampled: held high for k cycles, it clears k successive victims (victim re-evaluated each edge).
- rst_n low forces all counters, buf_num_replc and age_pls to 0 immediately, without a clock edge; first update on the first rising edge with rst_n high.
- Victim search is a combinational min-tree of NBUF−1 comparators; must close timing at NBUF=16, CNT_W=8.

## Configuration
- LFU_AGING_EN defined: saturation-triggered halving as in step 1; age_pls active.
- LFU_AGING_EN undefined: no aging logic; counters saturate at CMAX and hold; age_pls tied to 0.

## Test plan
(NBUF=4, CNT_W=4 unless stated.)
- Reset: drive rst_n low mid-cycle after activity -> cnt all 0, buf_num_replc=0, age_pls=0 before next edge.
- Refs 0,1,2,3,1,0,2 (one per cycle, ref_vld=1) -> cnt=2,2,2,1, buf_num_replc=3.
- Tie-break: refs 0,1 -> replc=2; refs 2,3 -> all 1 -> replc=0.
- Aging: 15 refs to 0, 2 refs to 1, then one more ref to 0 -> with LFU_AGING_EN: cnt=8,1,0,0, age_pls=1 for one cycle, replc=2; without: cnt=15,2,0,0, age_pls=0.
- Replacement: from cnt=3,2,2,4 (replc=1), new_buf_req alone -> cnt=3,0,2,4, replc=1; then new_buf_req with ref_vld ref=1 -> cnt1=1, replc=1; then ref_vld ref=3 with new_buf_req -> cnt=3,0,2,5, replc=1.
- NBUF=5, IDX_W=3: ref_buf_numbr=6 with ref_vld=1 -> no count change; refs 0..3 once -> replc=4.
